// File: rtl/pirdsp_mm9_sched.sv
// Two-requester scheduler for a 6-lane 9x9 multimult datapath: round-robin beat
// grant, per-requester dot-product accumulation, and a held result per requester.
module pirdsp_mm9_sched #(
    parameter int ACC_W = 48,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [53:0]      req0_a,
    input  logic [53:0]      req1_a,
    input  logic [53:0]      req0_b,
    input  logic [53:0]      req1_b,
    input  logic             req0_last,
    input  logic             req1_last,
    output logic [53:0]      mm_a,
    output logic [53:0]      mm_b,
    input  logic [44:0]      mm_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [ACC_W-1:0] res_hi,
    output logic [ACC_W-1:0] res_lo,
    output logic [CNT_W-1:0] res_beats,
    output logic             busy
);
    logic             ptr_q;
    logic [1:0]       blk_q;
    logic             s1_vld_q, s1_id_q, s1_last_q;
    logic [53:0]      mm_a_q, mm_b_q;
    logic [ACC_W-1:0] acc_hi_q [2];
    logic [ACC_W-1:0] acc_lo_q [2];
    logic [ACC_W-1:0] hold_hi_q [2];
    logic [ACC_W-1:0] hold_lo_q [2];
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] hold_cnt_q [2];
    logic [1:0]       pend_q;
    logic             res_valid_q, res_id_q;
    logic [ACC_W-1:0] res_hi_q, res_lo_q;
    logic [CNT_W-1:0] res_beats_q;

    logic [1:0]       elig_d, cand_d;
    logic             gnt_d, gnt_id_d, hs_d, load_d, sel_d;
    logic [ACC_W-1:0] term_hi_d, term_lo_d, sum_hi_d, sum_lo_d;
    logic [CNT_W-1:0] cnt_inc_d;

    // A requester that has issued its last beat stays locked out until its
    // result handshakes; blk_q clears on that edge, so it re-arbitrates next cycle.
    always_comb begin
        elig_d   = {req1_valid, req0_valid} & ~blk_q;
        gnt_d    = |elig_d;
        gnt_id_d = (elig_d == 2'b11) ? ptr_q : elig_d[1];
    end

    assign req0_ready = rst_n & gnt_d & ~gnt_id_d;
    assign req1_ready = rst_n & gnt_d & gnt_id_d;

    always_comb begin
        term_hi_d = ACC_W'($signed(mm_y[44:24]));
        term_lo_d = ACC_W'($signed(mm_y[23:0]));
        sum_hi_d  = acc_hi_q[s1_id_q] + term_hi_d;
        sum_lo_d  = acc_lo_q[s1_id_q] + term_lo_d;
        cnt_inc_d = cnt_q[s1_id_q] + 1'b1;
    end

    // The result being handshaked this cycle is excluded so the other pending
    // one can be latched on the same edge.
    always_comb begin
        hs_d      = res_valid_q & res_ready;
        load_d    = ~res_valid_q | hs_d;
        cand_d[0] = pend_q[0] & ~(hs_d & ~res_id_q);
        cand_d[1] = pend_q[1] & ~(hs_d & res_id_q);
        sel_d     = (cand_d == 2'b11) ? ~res_id_q : cand_d[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= 1'b0;
            blk_q       <= '0;
            s1_vld_q    <= 1'b0;
            s1_id_q     <= 1'b0;
            s1_last_q   <= 1'b0;
            mm_a_q      <= '0;
            mm_b_q      <= '0;
            pend_q      <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_hi_q    <= '0;
            res_lo_q    <= '0;
            res_beats_q <= '0;
            for (int r = 0; r < 2; r++) begin
                acc_hi_q[r]   <= '0;
                acc_lo_q[r]   <= '0;
                hold_hi_q[r]  <= '0;
                hold_lo_q[r]  <= '0;
                cnt_q[r]      <= '0;
                hold_cnt_q[r] <= '0;
            end
        end else begin
            s1_vld_q <= gnt_d;
            if (gnt_d) begin
                mm_a_q    <= gnt_id_d ? req1_a : req0_a;
                mm_b_q    <= gnt_id_d ? req1_b : req0_b;
                s1_id_q   <= gnt_id_d;
                s1_last_q <= gnt_id_d ? req1_last : req0_last;
                ptr_q     <= ~gnt_id_d;
                if (gnt_id_d ? req1_last : req0_last)
                    blk_q[gnt_id_d] <= 1'b1;
            end
            if (hs_d) begin
                blk_q[res_id_q]  <= 1'b0;
                pend_q[res_id_q] <= 1'b0;
            end
            if (s1_vld_q) begin
                if (s1_last_q) begin
                    hold_hi_q[s1_id_q]  <= sum_hi_d;
                    hold_lo_q[s1_id_q]  <= sum_lo_d;
                    hold_cnt_q[s1_id_q] <= cnt_inc_d;
                    pend_q[s1_id_q]     <= 1'b1;
                    acc_hi_q[s1_id_q]   <= '0;
                    acc_lo_q[s1_id_q]   <= '0;
                    cnt_q[s1_id_q]      <= '0;
                end else begin
                    acc_hi_q[s1_id_q] <= sum_hi_d;
                    acc_lo_q[s1_id_q] <= sum_lo_d;
                    cnt_q[s1_id_q]    <= cnt_inc_d;
                end
            end
            if (load_d) begin
                res_valid_q <= |cand_d;
                if (|cand_d) begin
                    res_id_q    <= sel_d;
                    res_hi_q    <= hold_hi_q[sel_d];
                    res_lo_q    <= hold_lo_q[sel_d];
                    res_beats_q <= hold_cnt_q[sel_d];
                end
            end
        end
    end

    assign mm_a      = mm_a_q;
    assign mm_b      = mm_b_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_hi    = res_hi_q;
    assign res_lo    = res_lo_q;
    assign res_beats = res_beats_q;
    assign busy      = s1_vld_q | (|pend_q) | (|cnt_q[0]) | (|cnt_q[1]);
endmodule

// File: doc/pirdsp_mm9_sched.md
PIRDSP_MM9_SCHED -- requirements
Module: pirdsp_mm9_sched

Interface
REQ-001 SHALL have parameter ACC_W, default 48, accumulator width in bits per half (min 24).
REQ-002 SHALL have parameter CNT_W, default 8, beat-counter width in bits.
REQ-003 SHALL have the following ports, one per line:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid / req1_valid  in  1  requester r beat valid.
- req0_ready / req1_ready  out  1  requester r beat accepted when valid&ready.
- req0_a / req1_a  in  54  six packed signed 9-bit lanes; lane k = bits [9k+8:9k].
- req0_b / req1_b  in  54  six packed signed 9-bit lanes, same packing.
- req0_last / req1_last  in  1  final beat of requester r's dot product.
- mm_a, mm_b  out  54  registered operands to the 6-lane 9x9 multimult datapath.
- mm_y  in  45  combinational datapath result of mm_a/mm_b: [44:24] = lanes 3..5 sum, [23:0] = lanes 0..2 sum.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when res_valid&res_ready.
- res_id  out  1  requester owning the result.
- res_hi, res_lo  out  ACC_W  signed accumulated upper/lower half sums.
- res_beats  out  CNT_W  beats accumulated in this result, modulo 2^CNT_W.
- busy  out  1  any beat in flight or any result pending.

Function
REQ-004 SHALL be a 2-stage pipeline: S1 registers granted beat into mm_a/mm_b with tag (id, last, vld); S2 adds sign-extended mm_y halves into acc_hi[id]/acc_lo[id].
REQ-005 SHALL grant at most one requester per cycle; reqN_ready SHALL be high only for the granted requester.
REQ-006 SHALL arbitrate round-robin among eligible valid requesters; priority pointer moves to the other requester after each grant; pointer resets to requester 0.
REQ-007 Requester r SHALL be ineligible from the cycle its last beat is granted until its result handshake completes.
REQ-008 mm_y[44:24] SHALL be treated as signed 21-bit, mm_y[23:0] as signed 24-bit, each sign-extended to ACC_W; accumulation wraps modulo 2^ACC_W.
REQ-009 Latency: beat accepted at edge t, mm_a/mm_b valid after t, accumulator updated at edge t+1; last beat's result visible on res_* after edge t+2 at earliest.
REQ-010 On S2 last for r, SHALL copy (acc + current term) and beat count+1 into hold[r], set pend[r], clear acc[r] and count[r] to 0 in the same edge.
REQ-011 When S1 is invalid, mm_a/mm_b SHALL hold value; accumulators SHALL not change.
REQ-012 Output selection SHALL latch when res_valid is low or on handshake: if both pend, pick requester opposite to last output; else the single pending one.
REQ-013 While res_valid&!res_ready, res_id/res_hi/res_lo/res_beats SHALL remain stable.
REQ-014 Handshake SHALL clear pend[res_id]; the other pending result SHALL present the next cycle.
REQ-015 Simultaneous handshake on r and new grant: requester r SHALL become eligible the cycle after the handshake, not the same cycle.
REQ-016 busy = S1 vld | pend[0] | pend[1] | count[0]!=0 | count[1]!=0.

Reset
REQ-017 rst_n low SHALL asynchronously clear: reqN_ready, res_valid, res_id, res_hi, res_lo, res_beats, busy, mm_a, mm_b, accumulators, counters, pend, S1 tag, pointers to 0.
REQ-018 Reset mid-operation SHALL drop all in-flight beats and partial sums; no result is emitted for them.
REQ-019 After rst_n deasserts, first grant SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-020 Req0 single beat, lane0 a=3 b=4, other lanes 0, last=1, res_ready=1 -> res_id=0, res_lo=12, res_hi=0, res_beats=1, 3 cycles after accept.
REQ-021 Req1 beats: lane5 a=0x1FF(-1) b=2; then lane3 a=100 b=100 last -> res_hi=9998, res_lo=0, res_beats=2.
REQ-022 Both valid continuously, 4-beat dot products -> grants alternate 0,1,0,1...; each result res_beats=4, results alternate id 0 then 1.
REQ-023 res_ready held low 10 cycles with both results pending -> res_* stable throughout, both requesters ready low after their last beats; release -> two results on consecutive cycles.
REQ-024 All lanes a=b=0x100(-256), 1 beat -> res_lo=196608, res_hi=196608.
REQ-025 rst_n pulsed low after 2 of 4 beats -> all outputs 0 immediately; a new 1-beat request afterward yields res_beats=1 and no residual sum.
